// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage
//                and the downstream control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    // Instruction held while nothing valid has been fetched (ADDI x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes shared with the control decoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // A fetch target is legal only on a 32-bit word boundary
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs != 2'b00);
    endfunction

    // Instruction field extractors
    function automatic logic [6:0] instr_op(input logic [31:0] word);
        return word[6:0];
    endfunction

    function automatic logic [2:0] instr_func3(input logic [31:0] word);
        return word[14:12];
    endfunction

    function automatic logic [6:0] instr_func7(input logic [31:0] word);
        return word[31:25];
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_sel
//  Description : Purely combinational next-PC resolution. Register-indirect
//                jump has the highest priority, then PC-relative jump or
//                taken branch, otherwise sequential. A Jr without Jump does
//                not redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            Branch,
    input  logic            Zero,
    input  logic            Jump,
    input  logic            Jr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] w_jr_target;
    logic [XLEN-1:0] w_rel_target;
    logic [XLEN-1:0] w_seq_target;
    logic            w_take_jr;
    logic            w_take_rel;

    // Candidate targets; all adds wrap at XLEN bits
    always_comb begin
        w_jr_target    = rs1_val + imm_ext;
        w_jr_target[0] = 1'b0;
        w_rel_target   = pc + imm_ext;
        w_seq_target   = pc + XLEN'(4);
    end

    // Priority select of the redirect source
    always_comb begin
        w_take_jr  = Jump & Jr;
        w_take_rel = Jump | (Branch & Zero);
        if (w_take_jr) begin
            next_pc = w_jr_target;
        end else if (w_take_rel) begin
            next_pc = w_rel_target;
        end else begin
            next_pc = w_seq_target;
        end
        misaligned = is_misaligned(next_pc[1:0]);
    end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage. Owns the PC, fetches one word per request over
//                a req/ack handshake, holds the instruction for the decoder
//                and advances the PC when execute accepts it.
//                Optional build macro MISALIGN_TRAP_EN: a misaligned next PC
//                parks the unit in FAULT (fetch_fault=1) until reset. Without
//                it the low two bits of the next PC are forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,

    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [6:0]       op,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,

    input  logic             Branch,
    input  logic             Jump,
    input  logic             Jr,
    input  logic             Zero,
    input  logic [XLEN-1:0]  imm_ext,
    input  logic [XLEN-1:0]  rs1_val,

    output logic [CNT_W-1:0] retire_count,
    output logic             fetch_fault
);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [31:0]      instr_q;
    logic [31:0]      instr_d;
    logic [CNT_W-1:0] retire_count_q;
    logic [CNT_W-1:0] retire_count_d;

    logic [XLEN-1:0]  w_next_pc;
    logic             w_misaligned;
    logic [XLEN-1:0]  w_next_pc_final;
    logic             w_trap;
    logic             w_accept;
    logic             w_capture;

    // ------------------------------------------------------------------------
    // Next-PC resolution
    // ------------------------------------------------------------------------
    next_pc_sel #(
        .XLEN (XLEN)
    ) u_next_pc_sel (
        .pc         (pc_q),
        .imm_ext    (imm_ext),
        .rs1_val    (rs1_val),
        .Branch     (Branch),
        .Zero       (Zero),
        .Jump       (Jump),
        .Jr         (Jr),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

`ifdef MISALIGN_TRAP_EN
    // Keep the raw target so the faulting address is visible on pc
    assign w_next_pc_final = w_next_pc;
    assign w_trap          = w_misaligned;
`else
    logic w_unused_lsbs;

    // Force word alignment; the misalignment flag has no consumer here
    assign w_next_pc_final = {w_next_pc[XLEN-1:2], 2'b00};
    assign w_trap          = 1'b0;
    assign w_unused_lsbs   = ^{w_misaligned, w_next_pc[1:0]};
`endif

    // Handshake qualifiers: ack only counts in REQ, accept only in HOLD
    assign w_accept  = (state_q == HOLD) & instr_ready;
    assign w_capture = (state_q == REQ) & imem_ack;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (w_capture) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    state_d = w_trap ? FAULT : REQ;
                end
            end
            FAULT: begin
`ifdef MISALIGN_TRAP_EN
                state_d = FAULT;
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM: Moore outputs; request and valid are mutually exclusive by state
    always_comb begin
        imem_req    = (state_q == REQ);
        instr_valid = (state_q == HOLD);
`ifdef MISALIGN_TRAP_EN
        fetch_fault = (state_q == FAULT);
`else
        fetch_fault = 1'b0;
`endif
    end

    // ------------------------------------------------------------------------
    // Datapath: PC advance, instruction capture, retire counting
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d           = pc_q;
        instr_d        = instr_q;
        retire_count_d = retire_count_q;
        if (w_capture) begin
            instr_d = imem_rdata;
        end
        if (w_accept) begin
            pc_d           = w_next_pc_final;
            retire_count_d = retire_count_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            retire_count_q <= '0;
        end else begin
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            retire_count_q <= retire_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + XLEN'(4);
    assign instr        = instr_q;
    assign op           = instr_op(instr_q);
    assign func3        = instr_func3(instr_q);
    assign func7        = instr_func7(instr_q);
    assign retire_count = retire_count_q;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Expected fetch
//                addresses are queued when an accept is driven and popped
//                when the DUT raises imem_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        Branch;
    logic        Jump;
    logic        Jr;
    logic        Zero;
    logic [31:0] imm_ext;
    logic [31:0] rs1_val;
    logic [31:0] retire_count;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_retire;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .op           (op),
        .func3        (func3),
        .func7        (func7),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .Branch       (Branch),
        .Jump         (Jump),
        .Jr           (Jr),
        .Zero         (Zero),
        .imm_ext      (imm_ext),
        .rs1_val      (rs1_val),
        .retire_count (retire_count),
        .fetch_fault  (fetch_fault)
    );

    // Advance one clock and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: a per-address scramble so every fetch is distinct
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
    endfunction

    // Wait for a request, check it against the scoreboard, answer after lat cycles
    task automatic do_fetch(input int lat);
        logic [31:0] e;
        logic [31:0] w;
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL fetch_req_timeout imem_req=%b required 1", imem_req);
            return;
        end
        checks++;
        if (exp_addr_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty unexpected request addr=%h", imem_addr);
            return;
        end
        e = exp_addr_q.pop_front();
        checks++;
        if (imem_addr !== e) begin
            failures++;
            $display("FAIL fetch_addr got=%h required=%h", imem_addr, e);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL req_valid_overlap instr_valid=%b required 0", instr_valid);
        end
        for (int i = 1; i < lat; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== e || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL req_hold req=%b addr=%h valid=%b required 1/%h/0",
                         imem_req, imem_addr, instr_valid, e);
            end
        end
        w          = mem_word(e);
        imem_rdata = w;
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL hold_entry valid=%b req=%b required 1/0", instr_valid, imem_req);
        end
        checks++;
        if (instr !== w) begin
            failures++;
            $display("FAIL instr got=%h required=%h", instr, w);
        end
        checks++;
        if (op !== w[6:0] || func3 !== w[14:12] || func7 !== w[31:25]) begin
            failures++;
            $display("FAIL fields got=%h/%h/%h required=%h/%h/%h",
                     op, func3, func7, w[6:0], w[14:12], w[31:25]);
        end
        checks++;
        if (pc !== e || pc_plus4 !== e + 32'd4) begin
            failures++;
            $display("FAIL pc got=%h/%h required=%h/%h", pc, pc_plus4, e, e + 32'd4);
        end
    endtask

    // Accept the held instruction with the given resolution, queue the expected target
    task automatic do_accept(input logic b, input logic z, input logic j, input logic jr,
                             input logic [31:0] imm, input logic [31:0] rs1,
                             input logic [31:0] exp_next);
        Branch      = b;
        Zero        = z;
        Jump        = j;
        Jr          = jr;
        imm_ext     = imm;
        rs1_val     = rs1;
        instr_ready = 1'b1;
        exp_addr_q.push_back(exp_next);
        exp_retire  = exp_retire + 32'd1;
        step();
        instr_ready = 1'b0;
        Branch      = 1'b0;
        Zero        = 1'b0;
        Jump        = 1'b0;
        Jr          = 1'b0;
        imm_ext     = 32'h0;
        rs1_val     = 32'h0;
        checks++;
        if (retire_count !== exp_retire) begin
            failures++;
            $display("FAIL retire_count got=%0d required=%0d", retire_count, exp_retire);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_after_accept instr_valid=%b required 0", instr_valid);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        Branch      = 1'b0;
        Zero        = 1'b0;
        Jump        = 1'b0;
        Jr          = 1'b0;
        imm_ext     = 32'h0;
        rs1_val     = 32'h0;
        exp_retire  = 32'h0;
        repeat (3) step();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl req=%b valid=%b fault=%b required 0/0/0",
                     imem_req, instr_valid, fetch_fault);
        end
        checks++;
        if (instr !== NOP_INSTR) begin
            failures++;
            $display("FAIL reset_instr got=%h required=%h", instr, NOP_INSTR);
        end
        checks++;
        if (pc !== RESET_PC || imem_addr !== RESET_PC || retire_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc pc=%h addr=%h retire=%0d required %h/%h/0",
                     pc, imem_addr, retire_count, RESET_PC, RESET_PC);
        end
        // Release; the first cycle is IDLE, and an ack there must be ignored
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_req imem_req=%b required 0", imem_req);
        end
        step();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || instr !== NOP_INSTR || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_req req=%b instr=%h valid=%b required 1/%h/0",
                     imem_req, instr, instr_valid, NOP_INSTR);
        end
        exp_addr_q.push_back(RESET_PC);
        do_fetch(1);
    endtask

    task automatic test_sequential();
        do_accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        do_fetch(3);
        do_accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
        do_fetch(3);
        do_accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC);
        do_fetch(3);
    endtask

    task automatic test_branch();
        do_accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10);
        do_fetch(1);
        do_accept(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h08);
        do_fetch(2);
        do_accept(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h10);
        do_fetch(1);
        do_accept(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h14);
        do_fetch(1);
    endtask

    task automatic test_jal();
        do_accept(1'b0, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 32'h20);
        do_fetch(1);
        step();
        checks++;
        if (pc_plus4 !== 32'h24 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL jal_link pc_plus4=%h valid=%b required 00000024/1", pc_plus4, instr_valid);
        end
        do_accept(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h120);
        do_fetch(2);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        held        = instr;
        instr_ready = 1'b0;
        Jump        = 1'b1;
        imm_ext     = 32'h40;
        for (int i = 0; i < 5; i++) begin
            imem_ack   = (i == 2);
            imem_rdata = 32'h1111_1111;
            step();
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== held ||
                pc !== 32'h120 || retire_count !== exp_retire) begin
                failures++;
                $display("FAIL backpressure cyc=%0d valid=%b req=%b instr=%h pc=%h retire=%0d required 1/0/%h/00000120/%0d",
                         i, instr_valid, imem_req, instr, pc, retire_count, held, exp_retire);
            end
        end
        imem_ack = 1'b0;
        Jump     = 1'b0;
        imm_ext  = 32'h0;
    endtask

    task automatic test_jr_only();
        do_accept(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h203, 32'h124);
        do_fetch(1);
    endtask

    task automatic test_jr();
`ifdef MISALIGN_TRAP_EN
        Jump        = 1'b1;
        Jr          = 1'b1;
        rs1_val     = 32'h203;
        imm_ext     = 32'h0;
        instr_ready = 1'b1;
        exp_retire  = exp_retire + 32'd1;
        step();
        instr_ready = 1'b0;
        Jump        = 1'b0;
        Jr          = 1'b0;
        rs1_val     = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                pc !== 32'h202 || retire_count !== exp_retire) begin
                failures++;
                $display("FAIL jr_fault cyc=%0d fault=%b req=%b valid=%b pc=%h retire=%0d required 1/0/0/00000202/%0d",
                         i, fetch_fault, imem_req, instr_valid, pc, retire_count, exp_retire);
            end
            step();
        end
`else
        do_accept(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h203, 32'h200);
        do_fetch(1);
        checks++;
        if (fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL jr_nofault fetch_fault=%b required 0", fetch_fault);
        end
`endif
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        exp_addr_q.delete();
        exp_retire = 32'h0;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_refetch req=%b addr=%h fault=%b required 1/%h/0",
                     imem_req, imem_addr, fetch_fault, RESET_PC);
        end
        step();
        // Reset while the request is still waiting for its ack
        rst_n = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP_INSTR) begin
            failures++;
            $display("FAIL mid_reset req=%b valid=%b instr=%h required 0/0/%h",
                     imem_req, instr_valid, instr, NOP_INSTR);
        end
        // Late ack during the IDLE cycle after release must be dropped
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        imem_ack   = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== NOP_INSTR || imem_req !== 1'b1 ||
            retire_count !== 32'h0) begin
            failures++;
            $display("FAIL late_ack valid=%b instr=%h req=%b retire=%0d required 0/%h/1/0",
                     instr_valid, instr, imem_req, retire_count, NOP_INSTR);
        end
        exp_addr_q.push_back(RESET_PC);
        do_fetch(2);
        do_accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        do_fetch(1);
        checks++;
        if (exp_addr_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d required 0", exp_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_backpressure();
        test_jr_only();
        test_jr();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control decoder.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Holds the fetched instruction and presents op/func3/func7 to the decoder.
- Computes the next PC from the decoder/ALU resolution (Branch, Zero, Jump, Jr) when downstream accepts the instruction.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, first fetch address after reset
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  XLEN  fetch address (word aligned), stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/fields/pc valid for the decoder
instr_ready  in  1  execute accepts the instruction this cycle
instr  out  32  held instruction word
op  out  7  instr[6:0]
func3  out  3  instr[14:12]
func7  out  7  instr[31:25]
pc  out  XLEN  address of held instruction
pc_plus4  out  XLEN  pc+4, used for JAL link write-back (ResultSrc=10)
Branch  in  1  from decoder
Jump  in  1  from decoder
Jr  in  1  from decoder
Zero  in  1  ALU zero flag
imm_ext  in  XLEN  sign-extended immediate (ImmSrc-selected)
rs1_val  in  XLEN  register-file rs1 read data
retire_count  out  CNT_W  instructions accepted since reset
fetch_fault  out  1  misaligned target trap (MISALIGN_TRAP_EN only, else tied 0)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr_valid=0.
  - instr=32'h0000_0013 (ADDI x0,x0,0), retire_count=0, fetch_fault=0.
  - Applies mid-operation: an outstanding request is dropped.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ack: capture imem_rdata into instr, go HOLD. imem_ack may arrive in the first REQ cycle (minimum fetch latency 1 cycle from request to valid).
  - HOLD: instr_valid=1; instr, fields, pc, pc_plus4 stable. On instr_valid&instr_ready: pc<=next_pc, retire_count+=1 (wraps modulo 2^CNT_W), go REQ.
  - FAULT: exists only under the macro (see Optional Feature).
- imem_ack outside REQ is ignored.
- instr_valid and imem_req are never high together.
- next_pc is sampled only at the accept handshake, in priority order:
  - Jump&Jr: (rs1_val+imm_ext) with bit0 cleared.
  - else Jump | (Branch&Zero): pc+imm_ext.
  - else pc+4.
- All adds are XLEN-bit and wrap silently. Jr without Jump is treated as no redirect.
- Throughput: one instruction per two cycles at zero memory wait; each extra ack wait cycle adds one cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro: if next_pc[1:0]!=0 at accept, go to FAULT.
  - FAULT: fetch_fault=1, imem_req=0, instr_valid=0, pc holds the faulting target.
  - Only reset exits FAULT. retire_count still counts the faulting accept.
- Without the macro: next_pc[1:0] forced to 2'b00 and fetch_fault tied 0.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, REQ, HOLD, FAULT}.
  - NOP_INSTR=32'h0000_0013.
  - Opcode localparams OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111 (shared with decoder).
- One combinational sub-module next_pc_sel: inputs pc, imm_ext, rs1_val, Branch, Zero, Jump, Jr; outputs next_pc and misaligned.

Test Plan:
- Reset then release with zero-wait ack:
  - imem_req rises the 2nd cycle after release with addr=0.
  - instr_valid the following cycle.
  - instr=NOP held during reset.
- Sequential: instr_ready=1, no control asserted, ack latency 3 cycles → addresses 0x0, 0x4, 0x8; retire_count 1, 2, 3.
- BEQ at pc=0x10, imm_ext=-8:
  - Branch=1, Zero=1 → next addr 0x08.
  - Zero=0 → 0x14.
- JAL at pc=0x20, imm_ext=0x100, Jump=1 → next addr 0x120; pc_plus4=0x24 during HOLD.
- JR with rs1_val=0x203, imm_ext=0, Jump=Jr=1:
  - Macro off: rs1_val+imm_ext=0x203 has bit0 cleared → 0x202, then bits[1:0] forced → next addr 0x200.
  - Macro on: 0x202 has bit1 set → fetch_fault=1, imem_req stays 0.
- Backpressure and mid-request reset:
  - instr_ready=0 for 5 HOLD cycles → outputs stable, counter unchanged.
  - rst_n=0 during REQ with ack pending → next cycle imem_req=0; a late ack is ignored; refetch from RESET_PC.
